// File: rtl/add_rca_pipe_pkg.sv
// add_rca_pipe_pkg: shared defaults and full-adder helpers for the pipelined
// ripple-carry adder/subtractor (add_rca_pipe) and its segment (add_rca_seg).
//   DEF_WIDTH / DEF_SEG : default word width and bits per pipeline segment.
//   fa_sum / fa_carry   : single full-adder cell.
//   carry_into          : recovers the carry entering a bit from a, b and sum.
package add_rca_pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (ci & (x ^ y));
  endfunction

  // s = x ^ y ^ cin, so the incoming carry falls out of the same XOR.
  function automatic logic carry_into(input logic x, input logic y, input logic s);
    return x ^ y ^ s;
  endfunction

endpackage

// File: rtl/add_rca_seg.sv
// add_rca_seg: combinational SEG-bit ripple chain of full-adder cells.
//   sum   out SEG  segment sum
//   c_out out 1    carry out of the segment MSB
//   a, b  in  SEG  segment operands
//   c_in  in  1    carry into the segment LSB
module add_rca_seg
  import add_rca_pipe_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  output logic [SEG-1:0] sum,
  output logic           c_out,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in
);

  // Ripple the carry LSB to MSB through one full-adder cell per bit.
  always_comb begin
    logic cy_s;
    cy_s = c_in;
    sum  = '0;
    for (int i = 0; i < SEG; i++) begin
      sum[i] = fa_sum(a[i], b[i], cy_s);
      cy_s   = fa_carry(a[i], b[i], cy_s);
    end
    c_out = cy_s;
  end

endmodule

// File: rtl/add_rca_pipe.sv
// add_rca_pipe: pipelined ripple-carry adder/subtractor, one SEG-bit segment
// resolved per stage, valid/ready handshake on both sides.
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready depends only on output side)
//   a, b, c_in, sub      operands; sub=1 computes a-b and ignores c_in
//   out_valid/out_ready  output handshake
//   sum, c_out, ovf      registered result, MSB carry, signed overflow
module add_rca_pipe
  import add_rca_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  if (((WIDTH % SEG) != 0) || (WIDTH < SEG)) begin : g_bad_cfg
    $error("add_rca_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic adv_s;
  logic msb_cin_s;

  // The whole pipe moves together unless a result is waiting on downstream.
  always_comb begin
    adv_s = !out_valid || out_ready;
  end

  assign in_ready = adv_s;

  // Level k holds an operation about to have segment k added. word_r carries
  // finished sum segments below k and still-unprocessed A bits from k upward;
  // brem_r carries only the unprocessed part of B_eff, so it narrows per level.
  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    localparam int BW = WIDTH - k * SEG;

    logic             valid_r;
    logic             carry_r;
    logic [WIDTH-1:0] word_r;
    logic [BW-1:0]    brem_r;
    logic [SEG-1:0]   seg_sum_s;
    logic             seg_cout_s;
    logic [WIDTH-1:0] nxt_word_s;

    add_rca_seg #(.SEG(SEG)) u_seg (
      .sum   (seg_sum_s),
      .c_out (seg_cout_s),
      .a     (word_r[k*SEG +: SEG]),
      .b     (brem_r[SEG-1:0]),
      .c_in  (carry_r)
    );

    // Splice this stage's sum segment over the A segment it consumed.
    always_comb begin
      nxt_word_s               = word_r;
      nxt_word_s[k*SEG +: SEG] = seg_sum_s;
    end

    if (k == 0) begin : g_cap
      // Capture: B is inverted here so sub never travels down the pipe.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_r <= 1'b0;
          carry_r <= 1'b0;
          word_r  <= '0;
          brem_r  <= '0;
        end else if (adv_s) begin
          valid_r <= in_valid;
          word_r  <= a;
          brem_r  <= sub ? ~b : b;
          carry_r <= sub ? 1'b1 : c_in;
        end
      end
    end else begin : g_fwd
      // Forward the previous level's partial result and its segment carry.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_r <= 1'b0;
          carry_r <= 1'b0;
          word_r  <= '0;
          brem_r  <= '0;
        end else if (adv_s) begin
          valid_r <= g_lvl[k-1].valid_r;
          word_r  <= g_lvl[k-1].nxt_word_s;
          carry_r <= g_lvl[k-1].seg_cout_s;
          brem_r  <= g_lvl[k-1].brem_r[BW+SEG-1:SEG];
        end
      end
    end
  end

  // Carry into the word MSB, recovered inside the final segment.
  always_comb begin
    msb_cin_s = carry_into(g_lvl[STAGES-1].word_r[WIDTH-1],
                           g_lvl[STAGES-1].brem_r[SEG-1],
                           g_lvl[STAGES-1].seg_sum_s[SEG-1]);
  end

  // Output register: completes the final segment and holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv_s) begin
      out_valid <= g_lvl[STAGES-1].valid_r;
      sum       <= g_lvl[STAGES-1].nxt_word_s;
      c_out     <= g_lvl[STAGES-1].seg_cout_s;
      ovf       <= msb_cin_s ^ g_lvl[STAGES-1].seg_cout_s;
    end
  end

endmodule
